// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on start in IDLE; the registered sum/cout update once per addition.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             fa_s, fa_c;
    logic             last_bit;
    logic [WIDTH-1:0] psum_next;

    assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // Shift the new sum bit in at the MSB; written this way so WIDTH=1 needs no special case.
    always_comb begin
        psum_next            = psum_q >> 1;
        psum_next[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (state_q == StIdle && start) begin
            a_sh_d  = a;
            b_sh_d  = b;
            psum_d  = '0;
            cnt_d   = '0;
            carry_d = cin;
        end else if (state_q == StRun) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            psum_d  = psum_next;
            cnt_d   = cnt_q + CntW'(1);
            carry_d = fa_c;
            if (last_bit) begin
                sum_d  = psum_next;
                cout_d = fa_c;
            end
        end
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): scoreboard queue of expected {cout,sum},
// popped on each done pulse; immediate assertions at every comparison.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int failures = 0;
    logic [W:0] exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic tc);
        return {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    endfunction

    // One addition from IDLE: busy for W cycles with outputs held, then a one-cycle done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input bit perturb, input string tag);
        logic [W-1:0] held_sum;
        logic         held_cout;
        logic [W:0]   e;
        int           busy_cnt;
        bit           seen;
        held_sum  = sum;
        held_cout = cout;
        a = ta; b = tb; cin = tc; start = 1'b1;
        exp_q.push_back(model(ta, tb, tc));
        tick();
        start    = 1'b0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            check({tag, "_hold"}, {cout, sum}, {held_cout, held_sum});
            if (perturb && i == 2) begin
                a = ~ta; b = ta ^ tb; cin = ~tc; start = 1'b1;
            end
            if (perturb && i == 3) start = 1'b0;
            tick();
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_cycles"}, busy_cnt, W);
        check({tag, "_busy_at_done"}, busy, 0);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, sum, e[W-1:0]);
            check({tag, "_cout"}, cout, e[W]);
        end
        tick();
        check({tag, "_done_pulse_1cyc"}, done, 0);
        check({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int pulses;
        int last_k;
        logic [W:0] e;

        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op(8'h3C, 8'h0F, 1'b1, 1'b0, "op_3c_0f");
        check("op_3c_0f_const_sum", sum, 8'h4C);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "op_ripple");
        check("op_ripple_const_cout", cout, 1);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, "op_a5_5a");
        run_op(8'h00, 8'h00, 1'b0, 1'b0, "op_zero");
        run_op(8'h96, 8'h3B, 1'b0, 1'b1, "op_perturb");
        tick();
        check("perturb_no_second_op", busy, 0);

        // Start held high: back-to-back additions every W+2 cycles.
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        for (int j = 0; j < 4; j++) exp_q.push_back(model(8'h01, 8'h01, 1'b0));
        pulses = 0;
        last_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                if (pulses > 0) check("cont_interval", k - last_k, W + 2);
                else check("cont_first_done", k, W + 1);
                last_k = k;
                pulses++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("cont_sum", sum, e[W-1:0]);
                    check("cont_cout", cout, e[W]);
                end
            end
        end
        start = 1'b0;
        check("cont_pulses", pulses, 4);
        check("cont_queue_empty", exp_q.size(), 0);
        tick();
        check("cont_stop_idle", busy, 0);

        // Asynchronous reset mid-RUN at E4.
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 2) rst_n = 1'b1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_op(8'h12, 8'h34, 1'b1, 1'b0, "op_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single full-adder cell and a carry flip-flop. It accepts two parallel operands and a carry-in on a start strobe, then adds one bit per clock, LSB first. When the addition completes it presents a registered parallel sum and carry-out with a one-cycle done pulse. It sits directly downstream of the combinational full-adder cell and turns it into a multi-cycle word adder for area-constrained datapaths.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the accepting edge only
- b  input  WIDTH  operand B; sampled on the accepting edge only
- cin  input  1  carry-in; sampled on the accepting edge only
- busy  output  1  high while the adder is in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

## Operation
- Reset: asserting rst_n low forces state IDLE and clears all outputs and internal registers to 0 immediately, independent of clk (busy=0, done=0, sum=0, cout=0).
- FSM states:
  - IDLE: start=1 on an edge loads shift registers from a and b, loads the carry flop from cin, clears the bit counter, and moves to RUN. start=0 leaves the state in IDLE.
  - RUN: each edge adds the LSB of shift register A, the LSB of shift register B, and the carry flop in the full-adder cell.
    - The sum bit shifts into the MSB of a partial-sum register.
    - The carry flop takes the cell cout.
    - Both operand registers shift right by one.
    - The counter increments.
    - On the edge that processes bit WIDTH-1, sum is loaded from the completed partial sum, cout is loaded from the cell cout, and the state moves to DONE.
  - DONE: done=1 for exactly this one cycle. The next edge returns the state to IDLE unconditionally.
- Input sampling:
  - start is ignored in RUN and in DONE.
  - A start held high through DONE is accepted on the first IDLE edge.
  - a, b and cin are not sampled outside the accepting edge, so they may change freely during RUN.
- Output hold: sum and cout change only on the completing edge. They hold the last result through IDLE and through the next RUN.
- Arithmetic: the result equals the low WIDTH bits of a+b+cin, with cout as bit WIDTH. Operands are unsigned; overflow is reported only through cout.
- The counter width is the minimum number of bits that represents WIDTH-1, with a minimum of 1 bit.

## Timing
- Edges are numbered relative to the accepting edge E0, where start=1 and the state is IDLE.
- busy is high from after E0 until after E(WIDTH).
- The completing edge is E(WIDTH). done is high between E(WIDTH) and E(WIDTH+1), and sum and cout are valid from E(WIDTH).
- The state returns to IDLE at E(WIDTH+1). The earliest next acceptance is E(WIDTH+2).
- Throughput is one addition per WIDTH+2 cycles.
- WIDTH=1: RUN lasts one edge, and done follows at E1.
- Reset asserted mid-RUN or during DONE aborts the operation. No done pulse is produced, and sum and cout read 0.
- Reset deassertion is synchronised externally. The first edge after deassertion may accept start.

## Test plan
- WIDTH=8. After reset, check busy=0, done=0, sum=0x00, cout=0. Then apply a=0x3C, b=0x0F, cin=1, start=1 for one cycle. Required: busy high for 8 cycles, then done pulses one cycle with sum=0x4C and cout=0.
- Apply a=0xFF, b=0x01, cin=0. Required: done with sum=0x00, cout=1. This checks carry rippling through all 8 bits.
- Apply a=0xA5, b=0x5A, cin=1. Required: sum=0x00, cout=1. Then apply a=0x00, b=0x00, cin=0. Required: sum=0x00, cout=0, with the previous outputs held unchanged until the completing edge.
- Pulse start and change a and b mid-RUN. Required: the result reflects only the operands sampled at E0, and no second operation starts.
- Hold start high continuously with a=0x01, b=0x01, cin=0. Required: done pulses every 10 cycles, each with sum=0x02 and cout=0.
- Assert rst_n low at E4 of an operation on a=0xFF, b=0xFF. Required: outputs immediately 0, no done pulse, and a normal operation runs afterwards.
